read_rw: RTL

// - Read-side counterpart of the RW write stage: fetches each task's read-write object from the

---
 rtl/read_rw.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/read_rw.sv
// read_rw: fetches each task's read-write object from the tile data array and forwards task+object in order.
// Optional READ_RW_STATS_EN adds free-running performance counters on the register bus.

package read_rw_pkg;
  localparam int unsigned ID_W       = 4;
  localparam int unsigned MAX_OBJ_W  = 512;
  localparam int unsigned REG_ADDR_W = 8;

  typedef logic [5:0]      cq_slice_slot_t;
  typedef logic [3:0]      thread_id_t;
  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] locale;
    logic [3:0]  ttype;
    logic [31:0] args;
  } task_t;

  typedef struct packed {
    task_t                task_desc;
    logic [MAX_OBJ_W-1:0] object;
    cq_slice_slot_t       cq_slot;
    thread_id_t           thread;
  } rw_write_t;

  typedef struct packed {
    logic                  wvalid;
    logic [REG_ADDR_W-1:0] waddr;
    logic [31:0]           wdata;
    logic                  arvalid;
    logic [REG_ADDR_W-1:0] araddr;
  } reg_bus_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
  } reg_bus_rsp_t;

  localparam logic [REG_ADDR_W-1:0] REG_CORE_START         = 8'h00;
  localparam logic [REG_ADDR_W-1:0] REG_RW_BASE_ADDR       = 8'h04;
  localparam logic [REG_ADDR_W-1:0] REG_CORE_DEBUG_WORD    = 8'h08;
  localparam logic [REG_ADDR_W-1:0] REG_DEBUG_CAPACITY     = 8'h0c;
  localparam logic [REG_ADDR_W-1:0] REG_TILE_ID            = 8'h10;
  localparam logic [REG_ADDR_W-1:0] REG_CYCLES_NO_TASK     = 8'h80;
  localparam logic [REG_ADDR_W-1:0] REG_CYCLES_TASK_ACC    = 8'h84;
  localparam logic [REG_ADDR_W-1:0] REG_CYCLES_STALL_FULL  = 8'h88;
  localparam logic [REG_ADDR_W-1:0] REG_CYCLES_STALL_AR    = 8'h8c;
  localparam logic [REG_ADDR_W-1:0] REG_CYCLES_STALL_OUT   = 8'h90;
endpackage

module read_rw
  import read_rw_pkg::*;
#(
  parameter int unsigned TILE_ID      = 0,
  parameter int unsigned LOG_DEPTH    = 2,
  parameter int unsigned LOG_RW_WIDTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           task_in_valid,
  output logic           task_in_ready,
  input  task_t          task_in,
  input  cq_slice_slot_t task_in_cq_slot,
  input  thread_id_t     task_in_thread,
  output logic           arvalid,
  input  logic           arready,
  output logic [31:0]    araddr,
  output id_t            arid,
  input  logic           rvalid,
  output logic           rready,
  input  logic [511:0]   rdata,
  input  id_t            rid,
  output logic           task_out_valid,
  input  logic           task_out_ready,
  output rw_write_t      task_out,
  input  reg_bus_req_t   reg_bus_req,
  output reg_bus_rsp_t   reg_bus_rsp
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned PTR_W = LOG_DEPTH + 1;
  localparam int unsigned OBJ_W = 8 << LOG_RW_WIDTH;
  localparam int unsigned SEL_W = 6 - LOG_RW_WIDTH;

  task_t          ent_task   [DEPTH];
  cq_slice_slot_t ent_cq     [DEPTH];
  thread_id_t     ent_thread [DEPTH];
  logic [OBJ_W-1:0] ent_obj  [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;

  logic [PTR_W-1:0] head_q, tail_q, head_n_c, tail_n_c;
  logic             full_q;
  logic             empty_c;
  logic [31:0]      base_rw_addr;
  logic             err_sticky;
  logic             started;

  logic [LOG_DEPTH-1:0] head_idx_c, tail_idx_c, rsp_idx_c;
  logic             accept_c, rsp_hit_c, out_load_c, rid_ok_c;
  logic [OBJ_W-1:0] rsp_obj_c;

  assign rready        = 1'b1;
  assign head_idx_c    = head_q[LOG_DEPTH-1:0];
  assign tail_idx_c    = tail_q[LOG_DEPTH-1:0];
  assign rsp_idx_c     = rid[LOG_DEPTH-1:0];
  assign empty_c       = (head_q == tail_q);
  assign task_in_ready = !rst && !full_q && (!arvalid || arready);
  assign accept_c      = task_in_valid && task_in_ready;
  assign rsp_hit_c     = rvalid && rid_ok_c && ent_valid[rsp_idx_c] && !ent_done[rsp_idx_c];
  assign out_load_c    = ent_valid[head_idx_c] && ent_done[head_idx_c] &&
                         (!task_out_valid || task_out_ready);
  assign tail_n_c      = tail_q + PTR_W'(accept_c);
  assign head_n_c      = head_q + PTR_W'(out_load_c);

  // Ids carry the ring index zero-extended; anything above it marks a stray beat.
  if (ID_W > LOG_DEPTH) begin : g_rid_hi
    assign rid_ok_c = (rid[ID_W-1:LOG_DEPTH] == '0);
  end else begin : g_rid_full
    assign rid_ok_c = 1'b1;
  end

  // Object lane select within the 64-byte line, keyed by the low locale bits.
  if (SEL_W == 0) begin : g_whole_line
    assign rsp_obj_c = rdata;
  end else begin : g_lane
    logic [SEL_W-1:0] word_sel_c;
    assign word_sel_c = ent_task[rsp_idx_c].locale[SEL_W-1:0];
    assign rsp_obj_c  = rdata[32'(word_sel_c) * OBJ_W +: OBJ_W];
  end

  // Ring payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      ent_task[tail_idx_c]   <= task_in;
      ent_cq[tail_idx_c]     <= task_in_cq_slot;
      ent_thread[tail_idx_c] <= task_in_thread;
    end
    if (rsp_hit_c) ent_obj[rsp_idx_c] <= rsp_obj_c;
  end

  // Ring control, read-address channel and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      full_q         <= 1'b0;
      ent_valid      <= '0;
      ent_done       <= '0;
      arvalid        <= 1'b0;
      araddr         <= '0;
      arid           <= '0;
      task_out_valid <= 1'b0;
      task_out       <= '0;
      err_sticky     <= 1'b0;
    end else begin
      if (accept_c) begin
        ent_valid[tail_idx_c] <= 1'b1;
        ent_done[tail_idx_c]  <= 1'b0;
        arvalid               <= 1'b1;
        araddr                <= base_rw_addr + (task_in.locale << LOG_RW_WIDTH);
        arid                  <= ID_W'(tail_idx_c);
      end else if (arready) begin
        arvalid <= 1'b0;
      end

      if (rsp_hit_c) ent_done[rsp_idx_c] <= 1'b1;
      else if (rvalid) err_sticky <= 1'b1;

      if (out_load_c) begin
        ent_valid[head_idx_c] <= 1'b0;
        task_out_valid        <= 1'b1;
        task_out.task_desc    <= ent_task[head_idx_c];
        task_out.object       <= MAX_OBJ_W'(ent_obj[head_idx_c]);
        task_out.cq_slot      <= ent_cq[head_idx_c];
        task_out.thread       <= ent_thread[head_idx_c];
      end else if (task_out_ready) begin
        task_out_valid <= 1'b0;
      end

      head_q <= head_n_c;
      tail_q <= tail_n_c;
      full_q <= (head_n_c[LOG_DEPTH] != tail_n_c[LOG_DEPTH]) &&
                (head_n_c[LOG_DEPTH-1:0] == tail_n_c[LOG_DEPTH-1:0]);
    end
  end

`ifdef READ_RW_STATS_EN
  logic [31:0] cyc_no_task, cyc_task_acc, cyc_stall_full, cyc_stall_ar, cyc_stall_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_no_task    <= '0;
      cyc_task_acc   <= '0;
      cyc_stall_full <= '0;
      cyc_stall_ar   <= '0;
      cyc_stall_out  <= '0;
    end else if (started) begin
      if (!task_in_valid)                     cyc_no_task    <= cyc_no_task + 32'd1;
      if (accept_c)                           cyc_task_acc   <= cyc_task_acc + 32'd1;
      if (task_in_valid && full_q)            cyc_stall_full <= cyc_stall_full + 32'd1;
      if (arvalid && !arready)                cyc_stall_ar   <= cyc_stall_ar + 32'd1;
      if (task_out_valid && !task_out_ready)  cyc_stall_out  <= cyc_stall_out + 32'd1;
    end
  end
`endif

  logic unused_bits_c;
`ifdef READ_RW_STATS_EN
  assign unused_bits_c = ^reg_bus_req.wdata[31:30];
`else
  assign unused_bits_c = ^{reg_bus_req.wdata[31:30], started};
`endif

  // Configuration writes and one-cycle registered reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_rw_addr <= '0;
      started      <= 1'b0;
      reg_bus_rsp  <= '0;
    end else begin
      if (reg_bus_req.wvalid) begin
        if (reg_bus_req.waddr == REG_RW_BASE_ADDR) base_rw_addr <= {reg_bus_req.wdata[29:0], 2'b00};
        if (reg_bus_req.waddr == REG_CORE_START)   started      <= reg_bus_req.wdata[0];
      end
      reg_bus_rsp.rvalid <= reg_bus_req.arvalid;
      if (reg_bus_req.arvalid) begin
        case (reg_bus_req.araddr)
          REG_CORE_DEBUG_WORD: reg_bus_rsp.rdata <= 32'({err_sticky, full_q, empty_c, arvalid,
                                                         arready, rvalid, task_in_valid,
                                                         task_in_ready, task_out_valid,
                                                         task_out_ready});
          REG_DEBUG_CAPACITY:  reg_bus_rsp.rdata <= 32'(PTR_W'(tail_q - head_q));
          REG_RW_BASE_ADDR:    reg_bus_rsp.rdata <= base_rw_addr;
          REG_TILE_ID:         reg_bus_rsp.rdata <= 32'(TILE_ID);
`ifdef READ_RW_STATS_EN
          REG_CYCLES_NO_TASK:    reg_bus_rsp.rdata <= cyc_no_task;
          REG_CYCLES_TASK_ACC:   reg_bus_rsp.rdata <= cyc_task_acc;
          REG_CYCLES_STALL_FULL: reg_bus_rsp.rdata <= cyc_stall_full;
          REG_CYCLES_STALL_AR:   reg_bus_rsp.rdata <= cyc_stall_ar;
          REG_CYCLES_STALL_OUT:  reg_bus_rsp.rdata <= cyc_stall_out;
`endif
          default:             reg_bus_rsp.rdata <= '0;
        endcase
      end
    end
  end

endmodule
